tcdm_bank_arbiter: RTL and testbench

Per-bank N-to-1 round-robin arbiter sitting directly upstream of one TCDM SRAM bank. It multiplexes `NbPorts` hci_mem-style initiators (cores, DMA, HWPE ports) onto a single bank port. It tracks each granted transaction through the fixed bank read latency and routes `r_data`/`r_id`/`r_valid` back to the initiator that issued it. The request path is combinational, so it adds zero cycles to the bank's latency.

---
 rtl/tcdm_arb_pkg.sv | 23 ++
 rtl/tcdm_rr_pick.sv | 46 ++++
 rtl/tcdm_bank_arbiter.sv | 100 ++++++++++
 tb/tb_tcdm_bank_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_arb_pkg.sv
// tcdm_arb_pkg
// Shared types and helpers for the per-bank TCDM arbiter.
//   resp_track_t : one slot of the response-tracking shift register
//                  (valid flag + index of the initiator that was granted).
//   onehot_port  : converts a port index into a one-hot port vector.
// Port indices are carried at a fixed width of MaxIdxW bits, so any
// instantiation supports at most MaxPorts initiators. Users cast the
// index up to MaxIdxW bits and cast the one-hot result down to NbPorts bits.
package tcdm_arb_pkg;

  localparam int unsigned MaxPorts = 32;
  localparam int unsigned MaxIdxW  = $clog2(MaxPorts);

  typedef struct packed {
    logic               valid;
    logic [MaxIdxW-1:0] port;
  } resp_track_t;

  function automatic logic [MaxPorts-1:0] onehot_port(input logic [MaxIdxW-1:0] idx);
    return MaxPorts'(1) << idx;
  endfunction

endpackage

// File: rtl/tcdm_rr_pick.sv
// tcdm_rr_pick
// Combinational round-robin pick: rotate the request vector so that the
// current priority pointer sits at bit 0, take the lowest set bit, then
// rotate the result back into absolute port numbering.
//   req_i : request vector, one bit per initiator
//   rr_i  : round-robin pointer (highest-priority port this cycle)
//   idx_o : winning port; equals rr_i when nobody requests
//   any_o : at least one request is pending
module tcdm_rr_pick #(
  parameter int unsigned NbPorts = 4
) (
  input  logic [NbPorts-1:0]         req_i,
  input  logic [$clog2(NbPorts)-1:0] rr_i,
  output logic [$clog2(NbPorts)-1:0] idx_o,
  output logic                       any_o
);

  localparam int unsigned IdxW = $clog2(NbPorts);

  logic [NbPorts-1:0] req_rot;
  logic [IdxW-1:0]    off;
  logic [IdxW:0]      sum;

  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < NbPorts; i++) begin
      req_rot[i] = req_i[IdxW'((int'(rr_i) + i) % NbPorts)];
    end

    // Lowest set bit of the rotated vector = distance from rr_i to the winner.
    off = '0;
    for (int i = NbPorts - 1; i >= 0; i--) begin
      if (req_rot[i]) off = IdxW'(i);
    end

    // Un-rotate with a modular add (NbPorts need not be a power of two).
    sum = {1'b0, rr_i} + {1'b0, off};
    if (sum >= (IdxW + 1)'(NbPorts)) sum = sum - (IdxW + 1)'(NbPorts);
    idx_o = sum[IdxW-1:0];
  end

  assign any_o = |req_i;

endmodule

// File: rtl/tcdm_bank_arbiter.sv
// tcdm_bank_arbiter
// Per-bank N-to-1 round-robin arbiter in front of one TCDM SRAM bank.
// The request path is purely combinational (no added latency); every
// handshake is tracked through a BankLatency-deep shift register so the
// response valid is routed back to the initiator that issued it.
//   clk_i, rst_ni                      : clock, async active-low reset
//   req_i/gnt_o                        : per-initiator request / grant
//   add_i, wen_i, data_i, be_i, id_i   : per-initiator request payload
//   r_data_o, r_id_o                   : response data / ID, broadcast
//   r_valid_o                          : one-hot response valid
//   bank_req_o, bank_gnt_i, bank_*_o   : request port toward the bank
//   bank_r_data_i, bank_r_id_i         : response from the bank
module tcdm_bank_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int unsigned NbPorts     = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned BeWidth     = DataWidth / 8,
  parameter int unsigned IdWidth     = 1,
  parameter int unsigned BankLatency = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NbPorts-1:0]                req_i,
  output logic [NbPorts-1:0]                gnt_o,
  input  logic [NbPorts-1:0][AddrWidth-1:0] add_i,
  input  logic [NbPorts-1:0]                wen_i,
  input  logic [NbPorts-1:0][DataWidth-1:0] data_i,
  input  logic [NbPorts-1:0][BeWidth-1:0]   be_i,
  input  logic [NbPorts-1:0][IdWidth-1:0]   id_i,
  output logic [DataWidth-1:0]              r_data_o,
  output logic [IdWidth-1:0]                r_id_o,
  output logic [NbPorts-1:0]                r_valid_o,
  output logic                              bank_req_o,
  input  logic                              bank_gnt_i,
  output logic [AddrWidth-1:0]              bank_add_o,
  output logic                              bank_wen_o,
  output logic [DataWidth-1:0]              bank_data_o,
  output logic [BeWidth-1:0]                bank_be_o,
  output logic [IdWidth-1:0]                bank_id_o,
  input  logic [DataWidth-1:0]              bank_r_data_i,
  input  logic [IdWidth-1:0]                bank_r_id_i
);

  localparam int unsigned IdxW = $clog2(NbPorts);

  logic [IdxW-1:0] rr_q, rr_d, win_idx;
  logic            any_req, hs;
  resp_track_t     push, tail;
  resp_track_t     track_q [BankLatency];

  tcdm_rr_pick #(.NbPorts(NbPorts)) i_pick (
    .req_i (req_i),
    .rr_i  (rr_q),
    .idx_o (win_idx),
    .any_o (any_req)
  );

  // With no requests win_idx equals rr_q, so the idle bank outputs show
  // port rr_q and are always driven from real inputs (never X).
  assign bank_req_o  = any_req;
  assign bank_add_o  = add_i[win_idx];
  assign bank_wen_o  = wen_i[win_idx];
  assign bank_data_o = data_i[win_idx];
  assign bank_be_o   = be_i[win_idx];
  assign bank_id_o   = id_i[win_idx];

  assign hs    = any_req & bank_gnt_i;
  assign gnt_o = hs ? NbPorts'(onehot_port(MaxIdxW'(win_idx))) : '0;

  // Priority moves to the port after the winner, wrapping at the last port.
  assign rr_d = (win_idx == IdxW'(NbPorts - 1)) ? '0 : win_idx + IdxW'(1);

  assign push.valid = hs;
  assign push.port  = MaxIdxW'(win_idx);

  // NOTE: state is updated with non-blocking assignments only, so every
  // stage of the shift register samples its neighbour's pre-edge value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
      // NOTE: the tracking array is reset (unlike a data RAM) because its
      // valid bits must be cleared to drop in-flight responses.
      for (int i = 0; i < BankLatency; i++) track_q[i] <= '0;
    end else begin
      if (hs) rr_q <= rr_d;
      track_q[0] <= push;
      for (int i = 1; i < BankLatency; i++) track_q[i] <= track_q[i-1];
    end
  end

  assign tail = track_q[BankLatency-1];

  // Every handshake (read or write) produces exactly one response.
  assign r_valid_o = tail.valid ? NbPorts'(onehot_port(tail.port)) : '0;
  assign r_data_o  = bank_r_data_i;
  assign r_id_o    = bank_r_id_i;

endmodule

// File: tb/tb_tcdm_bank_arbiter.sv
// tb_tcdm_bank_arbiter
// Two arbiters share the initiator side: dut0 has BankLatency 1, dut1 has
// BankLatency 2. The stimulus process predicts each grant with a simple
// "first requester at or after the pointer" search and pushes the expected
// response (due cycle, port, data, id) onto a per-DUT queue; a bank model
// replays the scheduled data/id on the due cycle. An independent monitor
// at the falling edge pops and compares whenever a response is due.
module tb_tcdm_bank_arbiter;

  localparam int N = 4;

  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
    logic [0:0]  id;
  } exp_t;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic [N-1:0]        req_i;
  logic [N-1:0][31:0]  add_i;
  logic [N-1:0]        wen_i;
  logic [N-1:0][31:0]  data_i;
  logic [N-1:0][3:0]   be_i;
  logic [N-1:0][0:0]   id_i;
  logic                bank_gnt_i;

  logic [N-1:0] gnt       [2];
  logic [N-1:0] r_valid   [2];
  logic [31:0]  r_data    [2];
  logic [0:0]   r_id      [2];
  logic         bank_req  [2];
  logic [31:0]  bank_add  [2];
  logic         bank_wen  [2];
  logic [31:0]  bank_data [2];
  logic [3:0]   bank_be   [2];
  logic [0:0]   bank_id   [2];
  logic [31:0]  bank_r_data [2];
  logic [0:0]   bank_r_id   [2];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rr_m = 0;
  bit   done = 1'b0;
  exp_t q [2][$];

  logic [31:0] sch_data [2][16];
  logic [0:0]  sch_id   [2][16];
  bit          sch_v    [2][16];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  tcdm_bank_arbiter #(.NbPorts(N), .BankLatency(1)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt[0]),
    .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .be_i(be_i), .id_i(id_i),
    .r_data_o(r_data[0]), .r_id_o(r_id[0]), .r_valid_o(r_valid[0]),
    .bank_req_o(bank_req[0]), .bank_gnt_i(bank_gnt_i), .bank_add_o(bank_add[0]),
    .bank_wen_o(bank_wen[0]), .bank_data_o(bank_data[0]), .bank_be_o(bank_be[0]),
    .bank_id_o(bank_id[0]), .bank_r_data_i(bank_r_data[0]), .bank_r_id_i(bank_r_id[0])
  );

  tcdm_bank_arbiter #(.NbPorts(N), .BankLatency(2)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt[1]),
    .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .be_i(be_i), .id_i(id_i),
    .r_data_o(r_data[1]), .r_id_o(r_id[1]), .r_valid_o(r_valid[1]),
    .bank_req_o(bank_req[1]), .bank_gnt_i(bank_gnt_i), .bank_add_o(bank_add[1]),
    .bank_wen_o(bank_wen[1]), .bank_data_o(bank_data[1]), .bank_be_o(bank_be[1]),
    .bank_id_o(bank_id[1]), .bank_r_data_i(bank_r_data[1]), .bank_r_id_i(bank_r_id[1])
  );

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rand_fields();
    for (int p = 0; p < N; p++) begin
      add_i[p]  = $urandom();
      wen_i[p]  = 1'($urandom());
      data_i[p] = $urandom();
      be_i[p]   = 4'($urandom());
      id_i[p]   = 1'($urandom());
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      for (int s = 0; s < 16; s++) sch_v[k][s] = 1'b0;
    end
    rr_m = 0;
  endtask

  // Holds reset for two edges; called just after a rising edge.
  task automatic do_reset();
    rst_ni     = 1'b0;
    req_i      = '0;
    bank_gnt_i = 1'b0;
    clear_model();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // One bus cycle, entered 1 time unit after a rising edge.
  task automatic step(input logic [N-1:0] req, input bit gnt_in, input bit keep = 1'b0);
    int          w;
    bit          found;
    logic [N-1:0] exp_gnt;
    if (!keep) rand_fields();
    // Bank model: present any response scheduled for this cycle.
    for (int k = 0; k < 2; k++) begin
      int s = cyc % 16;
      if (sch_v[k][s]) begin
        bank_r_data[k] = sch_data[k][s];
        bank_r_id[k]   = sch_id[k][s];
        sch_v[k][s]    = 1'b0;
      end else begin
        bank_r_data[k] = $urandom();
        bank_r_id[k]   = 1'($urandom());
      end
    end
    req_i      = req;
    bank_gnt_i = gnt_in;
    #2;
    // Reference: first requester at or after the pointer, wrapping.
    w     = rr_m;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(rr_m + i) % N]) begin
        w     = (rr_m + i) % N;
        found = 1'b1;
      end
    end
    exp_gnt = (found && gnt_in) ? (N'(1) << w) : '0;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("gnt%0d", k), gnt[k] === exp_gnt, 64'(gnt[k]), 64'(exp_gnt));
      check($sformatf("bank_req%0d", k), bank_req[k] === found, 64'(bank_req[k]), 64'(found));
      check($sformatf("bank_add%0d", k), bank_add[k] === add_i[w], 64'(bank_add[k]), 64'(add_i[w]));
      check($sformatf("bank_data%0d", k), bank_data[k] === data_i[w],
            64'(bank_data[k]), 64'(data_i[w]));
      check($sformatf("bank_ctl%0d", k),
            {bank_wen[k], bank_be[k], bank_id[k]} === {wen_i[w], be_i[w], id_i[w]},
            64'({bank_wen[k], bank_be[k], bank_id[k]}), 64'({wen_i[w], be_i[w], id_i[w]}));
    end
    if (found && gnt_in) begin
      logic [31:0] d0 = $urandom();
      logic [31:0] d1 = $urandom();
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        e.due  = cyc + k + 1;
        e.port = w;
        e.data = (k == 0) ? d0 : d1;
        e.id   = id_i[w];
        q[k].push_back(e);
        sch_data[k][e.due % 16] = e.data;
        sch_id[k][e.due % 16]   = e.id;
        sch_v[k][e.due % 16]    = 1'b1;
      end
      rr_m = (w + 1) % N;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Response monitor, decoupled from stimulus.
  always @(negedge clk_i) begin : monitor
    exp_t        e;
    logic [N-1:0] ev;
    if (!done) begin
      for (int k = 0; k < 2; k++) begin
        if (q[k].size() > 0 && q[k][0].due < cyc) begin
          e = q[k].pop_front();
          check($sformatf("resp_missed%0d", k), 1'b0, 64'(cyc), 64'(e.due));
        end
        if (q[k].size() > 0 && q[k][0].due == cyc) begin
          e  = q[k].pop_front();
          ev = N'(1) << e.port;
          check($sformatf("r_valid%0d", k), r_valid[k] === ev, 64'(r_valid[k]), 64'(ev));
          check($sformatf("r_data%0d", k), r_data[k] === e.data, 64'(r_data[k]), 64'(e.data));
          check($sformatf("r_id%0d", k), r_id[k] === e.id, 64'(r_id[k]), 64'(e.id));
        end else begin
          check($sformatf("r_valid_idle%0d", k), r_valid[k] === '0, 64'(r_valid[k]), 64'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_ni     = 1'b0;
    req_i      = '0;
    bank_gnt_i = 1'b0;
    add_i      = '0;
    wen_i      = '0;
    data_i     = '0;
    be_i       = '0;
    id_i       = '0;
    for (int k = 0; k < 2; k++) begin
      bank_r_data[k] = '0;
      bank_r_id[k]   = '0;
    end
    clear_model();
    @(posedge clk_i);
    #1;
    do_reset();

    // Reset state: idle bank outputs show port 0, no grants.
    repeat (2) step('0, 1'b1);

    // Single read from port 2 at 0x40.
    rand_fields();
    add_i[2] = 32'h40;
    wen_i[2] = 1'b1;
    step(4'b0100, 1'b1, 1'b1);
    repeat (2) step('0, 1'b0);

    // All ports requesting from reset: 0,1,2,3,0,1.
    do_reset();
    repeat (6) step(4'b1111, 1'b1);
    repeat (2) step('0, 1'b0);

    // Pointer at 2 with ports 1 and 3: 3 wins, wrap, then 1.
    do_reset();
    step(4'b0010, 1'b1);
    step(4'b1010, 1'b1);
    step(4'b1010, 1'b1);
    repeat (2) step('0, 1'b0);

    // Bank stall for 3 cycles, then port 0 first.
    do_reset();
    repeat (3) step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b1);

    // Write from port 1 with be 0011 (response still issued).
    rand_fields();
    wen_i[1] = 1'b0;
    be_i[1]  = 4'b0011;
    step(4'b0010, 1'b1, 1'b1);
    repeat (3) step('0, 1'b0);

    // Sole requester may be granted back-to-back.
    repeat (3) step(4'b1000, 1'b1);

    // Reset the cycle after a grant: in-flight responses dropped.
    step(4'b0100, 1'b1);
    do_reset();
    repeat (3) step('0, 1'b0);
    step(4'b1100, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom()), ($urandom() % 4) != 0);
    end

    repeat (4) step('0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("drain%0d", k), q[k].size() == 0, 64'(q[k].size()), 64'(0));
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
